// File: rtl/axil_ram_v2.sv
// ---------------------------------------------------------------------------
// axil_ram_v2 -- AXI4-Lite slave RAM (scratch / descriptor memory)
//
// Wraps a byte-enabled simple-dual-port RAM (ram_sdp, defined below).
// Port A is driven by the AXI write path. Port B is driven by the AXI read path.
// AW and W are accepted independently and in either order.
// Read data is held stable while R is back-pressured.
// Only one read is outstanding at a time.
//
// Optional feature macro: AXIL_RAM_RANGE_CHECK_EN
//   defined   : addresses outside the window get SLVERR. They do not touch
//               the RAM, and out-of-range reads return zero data.
//   undefined : the word index is a plain bit slice of the address, so the
//               memory wraps modulo MEM_DEPTH. Every response is OKAY.
//
// Ports
//   clk_i, rst_i        : the only clock; asynchronous active-high reset
//   s_axil_aw*          : write address channel (awaddr/awvalid/awready)
//   s_axil_w*           : write data channel (wdata/wstrb/wvalid/wready)
//   s_axil_b*           : write response channel (bresp/bvalid/bready)
//   s_axil_ar*          : read address channel (araddr/arvalid/arready)
//   s_axil_r*           : read data channel (rdata/rresp/rvalid/rready)
//   r_state_dbg         : read FSM state (0 idle, 1 wait, 2 resp)
//
// Handshake rule, valid for every channel here: a transfer happens on the
// rising clock edge where valid and ready are both 1. A source holds valid
// and its payload until that edge. Every ready and valid driven by this block
// comes from registers only. Ready never depends on the matching valid.
// ---------------------------------------------------------------------------
module axil_ram_v2 #(
  parameter int              MEM_DEPTH    = 256,
  parameter int              BYTE_WIDTH   = 8,
  parameter int              BYTE_NUM     = 4,
  parameter int              READ_LATENCY = 1,
  parameter string           MEM_MODE     = "no_change",
  parameter string           MEM_FILE     = "",
  parameter longint unsigned BASE_ADDR    = 0,
  parameter int              ADDR_WIDTH   = 32,
  parameter int              DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [BYTE_NUM-1:0]   s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [1:0]            r_state_dbg
);

  localparam int              IDX_W    = $clog2(MEM_DEPTH);
  localparam int              ADDR_LSB = $clog2(BYTE_NUM * BYTE_WIDTH / 8);
  localparam int              CNT_W    = 3;
  localparam longint unsigned WINDOW   = longint'(MEM_DEPTH) * BYTE_NUM * BYTE_WIDTH / 8;
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  if (BYTE_WIDTH * BYTE_NUM != DATA_WIDTH) begin : g_bad_width
    $error("BYTE_WIDTH*BYTE_NUM must equal DATA_WIDTH");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("MEM_DEPTH must be a power of two >= 2");
  end
  if (READ_LATENCY < 0 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 0..4");
  end
  if (ADDR_WIDTH < ADDR_LSB + IDX_W) begin : g_bad_addr_width
    $error("ADDR_WIDTH too small for the memory window");
  end
  if (BASE_ADDR % WINDOW != 0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to the window size");
  end

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  // Low after reset until the first clock edge. This keeps every ready at 0
  // while reset is asserted, even though the held flags are already cleared.
  logic up;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) up <= 1'b0;
    else       up <= 1'b1;
  end

  // ------------------------------------------------------------ write path
  logic                  aw_held, w_held, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTE_NUM-1:0]   wstrb_q;
  logic                  aw_hs, w_hs, wr_issue, wr_in_range;
  logic [IDX_W-1:0]      wr_idx;

  assign s_axil_awready = up & ~aw_held & ~bvalid_q;
  assign s_axil_wready  = up & ~w_held & ~bvalid_q;
  assign aw_hs          = s_axil_awvalid & s_axil_awready;
  assign w_hs           = s_axil_wvalid & s_axil_wready;
  assign wr_issue       = aw_held & w_held;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      // The readies are low while both flags are set or bvalid is high.
      // Therefore a capture never coincides with an issue or a pending response.
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (wr_issue) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------- read path
  r_state_t              r_state_q, r_state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, rd_load, rd_in_range, b_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] b_data;

  always_comb begin
    r_state_d      = r_state_q;
    cnt_d          = cnt_q;
    s_axil_arready = 1'b0;
    b_en           = 1'b0;
    rd_load        = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axil_arready = up;
        if (up && s_axil_arvalid) begin
          r_state_d = R_WAIT;
          cnt_d     = '0;
        end
      end
      R_WAIT: begin
        // The RAM is enabled once. Its output pipeline keeps shifting until the
        // word reaches the end after READ_LATENCY cycles.
        b_en  = (cnt_q == '0) & rd_in_range;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_W'(READ_LATENCY)) begin
          rd_load   = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs = s_axil_arvalid & s_axil_arready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (ar_hs) ar_addr_q <= s_axil_araddr;
      if (rd_load) begin
        rdata_q <= rd_in_range ? b_data : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axil_rvalid = (r_state_q == R_RESP);
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign r_state_dbg   = r_state_q;

  // ------------------------------------------------------ address decoding
  logic unused_bits;

`ifdef AXIL_RAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] WIN_EXT  = (ADDR_WIDTH + 1)'(WINDOW);
  logic [ADDR_WIDTH:0] aw_off, ar_off;

  // An address below the base wraps into the extra top bit.
  // One unsigned compare therefore covers both ends of the window.
  assign aw_off      = {1'b0, aw_addr_q} - BASE_EXT;
  assign ar_off      = {1'b0, ar_addr_q} - BASE_EXT;
  assign wr_in_range = (aw_off < WIN_EXT);
  assign rd_in_range = (ar_off < WIN_EXT);
  assign wr_idx      = aw_off[ADDR_LSB +: IDX_W];
  assign rd_idx      = ar_off[ADDR_LSB +: IDX_W];
  assign unused_bits = ^{aw_off, ar_off, aw_addr_q, ar_addr_q};
`else
  // BASE_ADDR is aligned to the window, so the subtraction only changes bits
  // above the index. A plain slice gives the index modulo MEM_DEPTH.
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
  assign wr_idx      = aw_addr_q[ADDR_LSB +: IDX_W];
  assign rd_idx      = ar_addr_q[ADDR_LSB +: IDX_W];
  assign unused_bits = ^{aw_addr_q, ar_addr_q};
`endif

  ram_sdp #(
    .DEPTH        (MEM_DEPTH),
    .BYTE_WIDTH   (BYTE_WIDTH),
    .BYTE_NUM     (BYTE_NUM),
    .READ_LATENCY (READ_LATENCY),
    .MEM_MODE     (MEM_MODE),
    .MEM_FILE     (MEM_FILE)
  ) u_ram (
    .clk      (clk_i),
    .a_en     (wr_issue & wr_in_range),
    .a_wr_en  (wstrb_q),
    .a_addr   (wr_idx),
    .a_data   (wdata_q),
    .b_en     (b_en),
    .b_addr   (rd_idx),
    .b_data_o (b_data)
  );

endmodule

// ---------------------------------------------------------------------------
// ram_sdp -- byte-enabled simple dual-port RAM
//
// Port A writes the byte lanes selected by a_wr_en when a_en is high.
// Port B reads the word at b_addr when b_en is high. The word appears on
// b_data_o after READ_LATENCY clocks, or combinationally when READ_LATENCY
// is 0.
// On a same-word collision, "no_change" and "read_first" return the old word.
// "write_first" forwards the bytes being written.
// Memory starts uninitialised; a non-empty MEM_FILE is rejected at
// elaboration.
// ---------------------------------------------------------------------------
module ram_sdp #(
  parameter int    DEPTH        = 256,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    BYTE_NUM     = 4,
  parameter int    READ_LATENCY = 1,
  parameter string MEM_MODE     = "no_change",
  parameter string MEM_FILE     = ""
) (
  input  logic                           clk,
  input  logic                           a_en,
  input  logic [BYTE_NUM-1:0]            a_wr_en,
  input  logic [$clog2(DEPTH)-1:0]       a_addr,
  input  logic [BYTE_NUM*BYTE_WIDTH-1:0] a_data,
  input  logic                           b_en,
  input  logic [$clog2(DEPTH)-1:0]       b_addr,
  output logic [BYTE_NUM*BYTE_WIDTH-1:0] b_data_o
);

  localparam int DW          = BYTE_NUM * BYTE_WIDTH;
  localparam bit WRITE_FIRST = (MEM_MODE == "write_first");

  if (MEM_MODE != "no_change" && MEM_MODE != "read_first" && MEM_MODE != "write_first")
  begin : g_bad_mode
    $error("MEM_MODE must be no_change, read_first or write_first");
  end
  if (MEM_FILE != "") begin : g_no_preload
    $error("MEM_FILE preload is not supported by this RAM model");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (a_wr_en[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = mem[b_addr];
    if (WRITE_FIRST && a_en && (a_addr == b_addr)) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (a_wr_en[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign b_data_o = rd_word;
  end else begin : g_pipe_read
    logic [DW-1:0] pipe [READ_LATENCY];

    // Only the first stage is enabled. Later stages shift every cycle
    // because b_en pulses for just one cycle per read.
    always_ff @(posedge clk) begin
      if (b_en) pipe[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end

    assign b_data_o = pipe[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_axil_ram_v2.sv
// ---------------------------------------------------------------------------
// tb_axil_ram_v2 -- directed self-checking bench for axil_ram_v2
// (MEM_DEPTH 256, READ_LATENCY 1, BASE_ADDR 0, 32-bit address and data).
// Inputs are driven and outputs sampled on the falling clock edge.
// A ready seen at a falling edge therefore means the transfer completes at
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_axil_ram_v2;

  localparam int RL = 1;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp, r_state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  axil_ram_v2 #(
    .MEM_DEPTH    (256),
    .BYTE_WIDTH   (8),
    .BYTE_NUM     (4),
    .READ_LATENCY (RL),
    .MEM_MODE     ("no_change"),
    .MEM_FILE     (""),
    .BASE_ADDR    (0),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .r_state_dbg    (r_state_dbg)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------- driver tasks
  // Each driver is entered at a falling edge and returns at a falling edge.
  // lat is the number of cycles from the last address/data transfer cycle
  // to the first cycle in which the response valid is seen.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    n = 0; aw_done = 0; w_done = 0; resp = 2'bxx; lat = -1;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    lat = 1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; lat++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h got no B response", addr);
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    bit hs;
    n = 0; hs = 0; data = 'x; resp = 2'bxx; lat = -1;
    araddr = addr; arvalid = 1'b1;
    while (!hs && n < 50) begin
      hs = arvalid && arready;
      @(negedge clk); n++;
    end
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && n < 50) begin @(negedge clk); n++; lat++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h got no R response", addr);
    end else begin
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
      failures++; $display("FAIL reset_handshake got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp} !== 4'b0000 || rdata !== 32'h0) begin
      failures++; $display("FAIL reset_payload got bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111 || r_state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_release got rdy=%b st=%0d want rdy=111 st=0", {awready, wready, arready}, r_state_dbg);
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, lat);
    checks++;
    if (lat !== 2 || resp !== 2'b00) begin
      failures++; $display("FAIL basic_write got lat=%0d bresp=%b want lat=2 bresp=00", lat, resp);
    end
    axi_read(32'h04, d, resp, lat);
    checks++;
    if (lat !== RL + 2 || d !== 32'hDEADBEEF || resp !== 2'b00) begin
      failures++; $display("FAIL basic_read got lat=%0d rdata=%h rresp=%b want lat=3 DEADBEEF 00", lat, d, resp);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, resp, lat);
    wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1'b1;
    checks++;
    if (wready !== 1'b1) begin
      failures++; $display("FAIL wfirst_wready got=%b want=1", wready);
    end
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
        failures++; $display("FAIL wfirst_hold cyc=%0d got aw=%b w=%b b=%b want 1 0 0", i, awready, wready, bvalid);
      end
      if (i < 4) @(negedge clk);
    end
    awaddr = 32'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      failures++; $display("FAIL wfirst_issue got bvalid=%b awready=%b want 0 0", bvalid, awready);
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("FAIL wfirst_bvalid got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
    end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    axi_read(32'h08, d, resp, lat);
    checks++;
    if (d !== 32'hFFFF_5678) begin
      failures++; $display("FAIL wfirst_merge got=%h want=FFFF5678", d);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h10; wdata = 32'h7777_8888; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!(bvalid && rvalid) && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!(bvalid && rvalid)) begin
      failures++; $display("FAIL bp_responses got bvalid=%b rvalid=%b want 1 1", bvalid, rvalid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000 || rdata !== 32'hDEADBEEF) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b rdata=%h want=11000 DEADBEEF",
                             i, {bvalid, rvalid, awready, wready, arready}, rdata);
      end
      @(negedge clk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    checks++;
    if ({bvalid, rvalid} !== 2'b00 || {awready, wready, arready} !== 3'b111) begin
      failures++; $display("FAIL bp_release got v=%b rdy=%b want v=00 rdy=111", {bvalid, rvalid}, {awready, wready, arready});
    end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic [31:0] d; int lat, n;
    axi_write(32'h0C, 32'h1111_1111, 4'hF, resp, lat);
    awaddr = 32'h0C; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("FAIL coll_ready got=%b want=111", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1;
    checks++;
    if (r_state_dbg !== 2'd1) begin
      failures++; $display("FAIL coll_state got=%0d want=1", r_state_dbg);
    end
    n = 0;
    while (!rvalid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1111_1111) begin
      failures++; $display("FAIL coll_old_data got rvalid=%b rdata=%h want 1 11111111", rvalid, rdata);
    end
    rready = 1'b1; @(negedge clk); rready = 1'b0; bready = 1'b0;
    axi_read(32'h0C, d, resp, lat);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL coll_new_data got=%h want=A5A5A5A5", d);
    end
  endtask

  task automatic test_range();
    logic [1:0] wresp, resp; logic [31:0] d; int lat;
    axi_write(32'h000, 32'h0BAD_F00D, 4'hF, resp, lat);
    axi_write(32'h400, 32'h5555_AAAA, 4'hF, wresp, lat);
`ifdef AXIL_RAM_RANGE_CHECK_EN
    checks++;
    if (wresp !== 2'b10) begin failures++; $display("FAIL range_bresp got=%b want=10", wresp); end
    axi_read(32'h000, d, resp, lat);
    checks++;
    if (d !== 32'h0BAD_F00D) begin failures++; $display("FAIL range_word0 got=%h want=0BADF00D", d); end
    axi_read(32'h400, d, resp, lat);
    checks++;
    if (resp !== 2'b10 || d !== 32'h0) begin
      failures++; $display("FAIL range_read got rresp=%b rdata=%h want 10 00000000", resp, d);
    end
`else
    checks++;
    if (wresp !== 2'b00) begin failures++; $display("FAIL range_bresp got=%b want=00", wresp); end
    axi_read(32'h000, d, resp, lat);
    checks++;
    if (d !== 32'h5555_AAAA) begin failures++; $display("FAIL range_word0 got=%h want=5555AAAA", d); end
    axi_read(32'h400, d, resp, lat);
    checks++;
    if (resp !== 2'b00 || d !== 32'h5555_AAAA) begin
      failures++; $display("FAIL range_read got rresp=%b rdata=%h want 00 5555AAAA", resp, d);
    end
`endif
  endtask

  task automatic test_reset_midop();
    logic [1:0] resp; logic [31:0] d; int lat;
    bit stale;
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h14; awvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (r_state_dbg !== 2'd1 || awready !== 1'b0 || wready !== 1'b1) begin
      failures++; $display("FAIL midrst_setup got st=%0d aw=%b w=%b want 1 0 1", r_state_dbg, awready, wready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00000) begin
      failures++; $display("FAIL midrst_async got=%b want=00000", {bvalid, rvalid, awready, wready, arready});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bvalid || rvalid) stale = 1;
    end
    checks++;
    if (stale !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b want=0", stale); end
    axi_read(32'h04, d, resp, lat);
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst_mem04 got=%h want=DEADBEEF", d); end
    axi_read(32'h08, d, resp, lat);
    checks++;
    if (d !== 32'hFFFF_5678) begin failures++; $display("FAIL midrst_mem08 got=%h want=FFFF5678", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    int idx, last, n, got;
    vals[0] = 32'hCAFE_0001; vals[1] = 32'h0BEE_F002;
    vals[2] = 32'h1234_0003; vals[3] = 32'h9ABC_0004;
    // Writes with bready tied high: one accepted every 3 cycles.
    bready = 1'b1;
    idx = 0; last = 0; n = 0;
    awaddr = 32'h20; wdata = vals[0]; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    while (idx < 4 && n < 100) begin
      if (awready && wready) begin
        if (idx > 0) begin
          checks++;
          if (n - last !== 3) begin failures++; $display("FAIL b2b_wr_period got=%0d want=3", n - last); end
        end
        last = n; idx++;
        @(negedge clk); n++;
        if (idx < 4) begin awaddr = 32'h20 + 32'(idx * 4); wdata = vals[idx]; end
        else begin awvalid = 1'b0; wvalid = 1'b0; end
      end else begin
        @(negedge clk); n++;
      end
    end
    repeat (3) @(negedge clk);
    bready = 1'b0;
    // Reads with rready tied high: one accepted every 3+RL cycles.
    rready = 1'b1;
    idx = 0; got = 0; last = 0; n = 0;
    araddr = 32'h20; arvalid = 1'b1;
    while (got < 4 && n < 100) begin
      if (rvalid) begin
        checks++;
        if (exp_q.size() == 0 || rdata !== exp_q[0]) begin
          failures++; $display("FAIL b2b_rdata idx=%0d got=%h want=%h", got, rdata, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (arvalid && arready) begin
        exp_q.push_back(vals[idx]);
        if (idx > 0) begin
          checks++;
          if (n - last !== 3 + RL) begin failures++; $display("FAIL b2b_rd_period got=%0d want=%0d", n - last, 3 + RL); end
        end
        last = n; idx++;
        @(negedge clk); n++;
        if (idx < 4) araddr = 32'h20 + 32'(idx * 4);
        else arvalid = 1'b0;
      end else begin
        @(negedge clk); n++;
      end
    end
    rready = 1'b0;
    checks++;
    if (got !== 4) begin failures++; $display("FAIL b2b_rd_count got=%0d want=4", got); end
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_backpressure();
    test_collision();
    test_reset_midop();
    test_back_to_back();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
